// File: rtl/wb_trace_uart_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// wb_trace_uart_pkg : shared constants, record type and frame builder
// Rev 1.0
// ============================================================================
package wb_trace_uart_pkg;

  localparam logic [7:0] TRACE_SYNC_BYTE   = 8'hA5;
  localparam int         TRACE_FRAME_BYTES = 10;
  localparam int         TRACE_REC_W       = 69;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  waddr;
    logic [31:0] data;
  } trace_rec_t;

  typedef enum logic [1:0] {
    SER_IDLE = 2'd0,
    SER_LOAD = 2'd1,
    SER_SEND = 2'd2
  } ser_state_t;

  function automatic logic [79:0] build_frame(input trace_rec_t rec);
    return {TRACE_SYNC_BYTE, rec.pc, 3'b000, rec.waddr, rec.data};
  endfunction

endpackage
`default_nettype wire

// File: rtl/wb_trace_uart_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// uart_tx : 8N1 byte transmitter; a new byte may start in the last stop cycle
// Rev 1.0
// ============================================================================
module uart_tx #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_start,
  input  logic [7:0] i_byte,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_tx
);
  localparam int CNT_W = $clog2(CLKS_PER_BIT);

  typedef enum logic [1:0] {
    U_IDLE  = 2'd0,
    U_START = 2'd1,
    U_DATA  = 2'd2,
    U_STOP  = 2'd3
  } uart_state_t;

  uart_state_t      r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_bit;
  logic [7:0]       r_shift;
  logic             r_tx;
  logic             w_bit_end;
  logic             w_done;
  logic             w_accept;

  assign w_bit_end = (r_cnt == CNT_W'(CLKS_PER_BIT - 1));
  assign w_done    = (r_state == U_STOP) && w_bit_end;
  // Accepting on the final stop cycle gives gap-free back-to-back bytes.
  assign w_accept  = i_start && ((r_state == U_IDLE) || w_done);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= U_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
    end else if (w_accept) begin
      r_state <= U_START;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= i_byte;
      r_tx    <= 1'b0;
    end else if (r_state != U_IDLE) begin
      if (!w_bit_end) begin
        r_cnt <= r_cnt + 1'b1;
      end else begin
        r_cnt <= '0;
        case (r_state)
          U_START: begin
            r_state <= U_DATA;
            r_tx    <= r_shift[0];
          end
          U_DATA: begin
            if (r_bit == 3'd7) begin
              r_state <= U_STOP;
              r_tx    <= 1'b1;
            end else begin
              r_bit   <= r_bit + 1'b1;
              r_shift <= r_shift >> 1;
              r_tx    <= r_shift[1];
            end
          end
          default: r_state <= U_IDLE;
        endcase
      end
    end
  end

  assign o_busy = (r_state != U_IDLE);
  assign o_done = w_done;
  assign o_tx   = r_tx;

endmodule
`default_nettype wire

// File: rtl/wb_trace_uart.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// wb_trace_uart : captures register-file writes into a FIFO, sends 10-byte frames
// Rev 1.0
// ============================================================================
module wb_trace_uart
  import wb_trace_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_write_en_wb,
  input  logic [4:0]  i_waddr_wb,
  input  logic [31:0] i_pc_wb,
  input  logic [31:0] i_write_data_wb,
  input  logic        i_enable,
  output logic        o_tx,
  output logic        o_tx_busy,
  output logic        o_overflow,
  output logic [7:0]  o_drop_count
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  trace_rec_t   r_mem [FIFO_DEPTH];
  logic [PTR_W:0] r_wr_ptr;
  logic [PTR_W:0] r_rd_ptr;
  logic         r_overflow;
  logic [7:0]   r_drop_count;
  ser_state_t   r_state;
  logic [3:0]   r_idx;
  logic [79:0]  r_frame;

  logic         w_empty;
  logic         w_full;
  logic         w_capture;
  logic         w_push;
  logic         w_drop;
  logic         w_last;
  logic         w_start;
  logic [7:0]   w_byte;
  logic         w_uart_busy;
  logic         w_uart_done;
  logic [79:0]  w_head_frame;

  assign w_empty   = (r_wr_ptr == r_rd_ptr);
  assign w_full    = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                     (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
  assign w_capture = i_enable && i_write_en_wb && (i_waddr_wb != 5'd0);
  assign w_push    = w_capture && !w_full;
  assign w_drop    = w_capture && w_full;
  assign w_head_frame = build_frame(r_mem[r_rd_ptr[PTR_W-1:0]]);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[PTR_W-1:0]] <= {i_pc_wb, i_waddr_wb, i_write_data_wb};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_overflow   <= 1'b0;
      r_drop_count <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (r_state == SER_LOAD) r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_drop_count != 8'hFF) r_drop_count <= r_drop_count + 1'b1;
      end
    end
  end

  // The sync byte of a chained frame is started from the last stop cycle of
  // the previous frame, so LOAD only starts it when the line is idle.
  assign w_last  = (r_idx == 4'(TRACE_FRAME_BYTES - 1));
  assign w_start = ((r_state == SER_LOAD) && !w_uart_busy) ||
                   ((r_state == SER_SEND) && w_uart_done && (!w_last || !w_empty));
  assign w_byte  = ((r_state == SER_LOAD) || w_last) ? TRACE_SYNC_BYTE : r_frame[79:72];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= SER_IDLE;
      r_idx   <= '0;
      r_frame <= '0;
    end else begin
      case (r_state)
        SER_IDLE: begin
          if (!w_empty) r_state <= SER_LOAD;
        end
        SER_LOAD: begin
          r_frame <= {w_head_frame[71:0], 8'h00};
          r_idx   <= '0;
          r_state <= SER_SEND;
        end
        SER_SEND: begin
          if (w_uart_done) begin
            if (w_last) begin
              r_state <= w_empty ? SER_IDLE : SER_LOAD;
            end else begin
              r_idx   <= r_idx + 1'b1;
              r_frame <= {r_frame[71:0], 8'h00};
            end
          end
        end
        default: r_state <= SER_IDLE;
      endcase
    end
  end

  uart_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart_tx (
    .clk    (clk),
    .rst    (rst),
    .i_start(w_start),
    .i_byte (w_byte),
    .o_busy (w_uart_busy),
    .o_done (w_uart_done),
    .o_tx   (o_tx)
  );

  assign o_tx_busy    = !w_empty || (r_state != SER_IDLE);
  assign o_overflow   = r_overflow;
  assign o_drop_count = r_drop_count;

endmodule
`default_nettype wire

// File: tb/tb_wb_trace_uart.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_wb_trace_uart : scoreboard bench, UART line decoded by a monitor process
// Rev 1.0
// ============================================================================
module tb_wb_trace_uart;
  localparam int CPB   = 4;
  localparam int DEPTH = 16;

  typedef struct {
    logic [7:0] b;
    bit         contig;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        we = 1'b0;
  logic [4:0]  waddr = '0;
  logic [31:0] pc = '0;
  logic [31:0] wdata = '0;
  logic        en = 1'b1;
  logic        tx;
  logic        busy;
  logic        ovf;
  logic [7:0]  drops;

  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  bit   discard = 1'b0;
  exp_t sb[$];

  wb_trace_uart #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .i_write_en_wb  (we),
    .i_waddr_wb     (waddr),
    .i_pc_wb        (pc),
    .i_write_data_wb(wdata),
    .i_enable       (en),
    .o_tx           (tx),
    .o_tx_busy      (busy),
    .o_overflow     (ovf),
    .o_drop_count   (drops)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_byte(input logic [7:0] b, input bit contig);
    exp_t e;
    e.b = b;
    e.contig = contig;
    sb.push_back(e);
  endtask

  task automatic push_frame(input logic [31:0] p, input logic [4:0] a, input logic [31:0] d,
                            input bit contig);
    push_byte(8'hA5, contig);
    push_byte(p[31:24], 1'b1); push_byte(p[23:16], 1'b1);
    push_byte(p[15:8], 1'b1);  push_byte(p[7:0], 1'b1);
    push_byte({3'b000, a}, 1'b1);
    push_byte(d[31:24], 1'b1); push_byte(d[23:16], 1'b1);
    push_byte(d[15:8], 1'b1);  push_byte(d[7:0], 1'b1);
  endtask

  task automatic drive(input logic w, input logic [4:0] a, input logic [31:0] p, input logic [31:0] d);
    @(negedge clk);
    we = w; waddr = a; pc = p; wdata = d;
  endtask

  task automatic wait_drain(input string name, input int limit);
    int n = 0;
    while ((sb.size() != 0 || busy) && n < limit) begin
      @(posedge clk); #1;
      n++;
    end
    check(name, 32'(n < limit), 32'd1);
  endtask

  // Line monitor: decodes each 8N1 byte and compares with the scoreboard head.
  initial begin : monitor
    int start_cyc;
    int last_start;
    logic [7:0] rx;
    logic stop_bit;
    exp_t e;
    last_start = -100000;
    forever begin
      @(negedge clk);
      if (tx === 1'b0) begin
        start_cyc = cyc;
        repeat (CPB + CPB/2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          rx[i] = tx;
          if (i < 7) repeat (CPB) @(negedge clk);
        end
        repeat (CPB) @(negedge clk);
        stop_bit = tx;
        repeat (CPB/2 - 1) @(negedge clk);
        if (!discard) begin
          if (sb.size() == 0) begin
            tests++; fails++;
            $display("FAIL unexpected_byte: got %0h expected none", rx);
          end else begin
            e = sb.pop_front();
            check("rx_byte", {23'd0, stop_bit, rx}, {23'd0, 1'b1, e.b});
            if (e.contig) check("byte_gap", 32'(start_cyc - last_start), 32'(10*CPB));
          end
        end
        last_start = start_cyc;
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int bad;
    repeat (3) @(posedge clk); #1;
    check("rst_tx", tx, 1);
    check("rst_busy", busy, 0);
    check("rst_ovf", ovf, 0);
    check("rst_drops", drops, 0);
    @(negedge clk); rst = 0;
    repeat (3) @(negedge clk);

    // Single record: x5 <= 0x12345678 at PC 0x100.
    push_byte(8'hA5, 0);
    push_byte(8'h00, 1); push_byte(8'h00, 1); push_byte(8'h01, 1); push_byte(8'h00, 1);
    push_byte(8'h05, 1);
    push_byte(8'h12, 1); push_byte(8'h34, 1); push_byte(8'h56, 1); push_byte(8'h78, 1);
    drive(1, 5'd5, 32'h0000_0100, 32'h1234_5678);
    @(posedge clk);                         // capture edge N
    @(negedge clk); we = 0;
    @(posedge clk); #1; check("tx_idle_n1", tx, 1);
    @(posedge clk); #1; check("tx_start_n2", tx, 0);
    check("busy_n2", busy, 1);
    repeat (399) @(posedge clk); #1; check("busy_n401", busy, 1);
    @(posedge clk); #1; check("busy_n402", busy, 0);
    check("s1_sb_empty", sb.size(), 0);

    // Writes to x0 and writes with capture disabled are ignored.
    for (int i = 0; i < 3; i++) drive(1, 5'd0, 32'h200 + i, 32'hDEAD_0000 + i);
    @(negedge clk); en = 0;
    for (int i = 0; i < 3; i++) drive(1, 5'd7, 32'h300 + i, 32'hBEEF_0000 + i);
    drive(0, 5'd0, 0, 0);
    en = 1;
    bad = 0;
    repeat (30) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    check("ignored_line_quiet", bad, 0);
    check("ignored_drops", drops, 0);
    check("ignored_ovf", ovf, 0);

    // 20 back-to-back writes: 17 frames sent, 3 dropped; then saturation.
    for (int i = 0; i < 20; i++) begin
      drive(1, 5'((i % 31) + 1), 32'h1000 + 32'(4*i), 32'hA000_0000 + 32'(i));
      if (i < 17) push_frame(32'h1000 + 32'(4*i), 5'((i % 31) + 1), 32'hA000_0000 + 32'(i), i != 0);
    end
    drive(0, 0, 0, 0);
    check("burst_drops", drops, 3);
    check("burst_ovf", ovf, 1);
    for (int i = 0; i < 300; i++) drive(1, 5'd9, 32'h5000 + 32'(i), 32'(i));
    drive(0, 0, 0, 0);
    check("sat_drops", drops, 255);
    wait_drain("burst_drain", 8000);
    check("sat_drops_after", drops, 255);
    check("ovf_sticky", ovf, 1);
    @(negedge clk); rst = 1;
    @(posedge clk); #1;
    check("clr_ovf", ovf, 0);
    check("clr_drops", drops, 0);
    @(negedge clk); rst = 0;

    // Reset in the middle of byte 4 of a frame with 5 records queued.
    discard = 1;
    for (int i = 0; i < 6; i++) drive(1, 5'd3, 32'h7000 + 32'(i), 32'h7700 + 32'(i));
    drive(0, 0, 0, 0);
    repeat (165) @(negedge clk);
    rst = 1;
    @(posedge clk); #1;
    check("mid_rst_tx", tx, 1);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_drops", drops, 0);
    check("mid_rst_ovf", ovf, 0);
    @(negedge clk); rst = 0;
    bad = 0;
    repeat (500) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    check("post_rst_quiet", bad, 0);
    discard = 0;
    push_frame(32'hCAFE_0010, 5'd31, 32'h0BAD_F00D, 0);
    drive(1, 5'd31, 32'hCAFE_0010, 32'h0BAD_F00D);
    drive(0, 0, 0, 0);
    wait_drain("post_rst_drain", 600);

    // Capture disabled during the first of four queued frames.
    for (int i = 0; i < 4; i++) begin
      drive(1, 5'(i + 10), 32'h8000_0000 + 32'(i), 32'h0F0F_0000 + 32'(i));
      push_frame(32'h8000_0000 + 32'(i), 5'(i + 10), 32'h0F0F_0000 + 32'(i), i != 0);
    end
    drive(0, 0, 0, 0);
    repeat (100) @(negedge clk);
    en = 0;
    for (int i = 0; i < 5; i++) drive(1, 5'd20, 32'h9000 + 32'(i), 32'(i));
    drive(0, 0, 0, 0);
    wait_drain("en_drain", 2500);
    check("en_drops", drops, 0);
    en = 1;

    repeat (60) @(negedge clk);
    check("final_sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
